v_sequential_store: RTL and testbench
=====================================

V_SEQUENTIAL_STORE -- requirements
Module: v_sequential_store

Interface
REQ-001 The block SHALL have parameter NrLaneEntriesNbs, default 64, meaning nibbles per sequential-buffer entry (DLEN/4*NrExits).
REQ-002 The block SHALL have parameter AxiDataWidth, default 128, giving BusNbs=AxiDataWidth/4 and BNS=$clog2(BusNbs).
REQ-003 The block SHALL have port clk_i, input, 1 bit: the single clock.
REQ-004 The block SHALL have port rst_i, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have ports rx_shfu_valid_i (in, 1), rx_shfu_ready_o (out, 1), rx_shfu_nb_i (in, NrLaneEntriesNbs*4) and rx_shfu_en_i (in, NrLaneEntriesNbs): the nibble entry from ShuffleUnit.
REQ-006 The block SHALL have ports meta_glb_valid_i (in, 1), meta_glb_ready_o (out, 1) and meta_seq_nb_ptr_i (in, $clog2(NrLaneEntriesNbs)): the start nibble pointer (vstart<<sew).
REQ-007 The block SHALL have ports txn_ctrl_valid_i (in, 1), txn_ctrl_ready_o (out, 1), txn_addr_lo_i (in, BNS), txn_lbn_i (in, BNS+1), txn_rmn_beat_i (in, 8), txn_is_head_i (in, 1) and txn_is_final_i (in, 1): per-beat transaction control.
REQ-008 The block SHALL have ports axi_w_valid_o (out, 1), axi_w_ready_i (in, 1), axi_w_data_o (out, AxiDataWidth), axi_w_strb_o (out, AxiDataWidth/8) and axi_w_last_o (out, 1): the AXI W channel.

Function
REQ-009 SeqBuf SHALL be a 2-entry ping-pong FIFO (data plus en) with flag/value enqueue and dequeue pointers; rx_shfu_ready_o = !full; enqueue on rx valid&&ready.
REQ-010 FSM states SHALL be S_IDLE and S_SERIAL.
REQ-011 In S_IDLE: txn_ctrl_valid_i&&meta_glb_valid_i SHALL assert meta_glb_ready_o, load seq_nb_ptr<=meta_seq_nb_ptr_i, clear bus_nb_cnt, and go to S_SERIAL next cycle; meta_glb_ready_o SHALL be 0 otherwise.
REQ-012 A W staging register (data, per-nibble written mask, last, w_valid) SHALL accumulate one beat; axi_w_valid_o=w_valid, and outputs SHALL be stable while valid&&!ready.
REQ-013 In S_SERIAL, a commit SHALL occur when txn_ctrl_valid_i && SeqBuf not empty && (!w_valid || axi_w_ready_i).
REQ-014 Commit arithmetic: lower=is_head?addr_lo:0; upper=(rmn_beat==0)?lbn:BusNbs; bus_valid=upper-lower-bus_nb_cnt; seq_valid=NrLaneEntriesNbs-seq_nb_ptr; n=min(bus_valid,seq_valid), all widened one bit, no wrap.
REQ-015 A commit SHALL copy head-entry nibbles [seq_nb_ptr, seq_nb_ptr+n) to bus nibbles starting at lower+bus_nb_cnt, setting written bits from the entry's en bits.
REQ-016 If bus_valid>seq_valid: the head SHALL be dequeued, seq_nb_ptr<=0 and bus_nb_cnt+=n, and the beat SHALL stay incomplete.
REQ-017 Otherwise: w_valid<=1, last<=(rmn_beat==0), txn_ctrl_ready_o=1 this cycle, bus_nb_cnt<=0 and seq_nb_ptr+=n; if bus_valid==seq_valid or final beat (is_final&&rmn_beat==0), the head SHALL be dequeued and seq_nb_ptr<=0.
REQ-018 A final-beat commit SHALL return the FSM to S_IDLE next cycle.
REQ-019 W handshake: a beat issued same cycle SHALL clear the staging data/mask before any commit writes; a commit in that cycle SHALL write into the cleared register (1 beat/cycle throughput).
REQ-020 Strobe: axi_w_strb_o[j] SHALL equal written[2j]; an assertion SHALL fire when written[2j]!=written[2j+1]; unwritten nibbles SHALL read 0.
REQ-021 Assertions SHALL check upper<=BusNbs, bus_valid<=BusNbs and seq_valid<=NrLaneEntriesNbs.
REQ-022 txn_ctrl_ready_o SHALL be 0 except under REQ-017; the latency from a completing commit to axi_w_valid_o SHALL be 1 cycle.

Reset
REQ-023 rst_i high at a clock edge SHALL force S_IDLE, empty SeqBuf with pointers 0, seq_nb_ptr=0, bus_nb_cnt=0, w_valid=0 and staging cleared; all valid/ready outputs SHALL be 0 during reset, and a mid-transfer reset SHALL drop partial beats with no W output.

Verification
REQ-024 Aligned single beat: ptr=0, head, addr_lo=0, lbn=32, rmn=0, final, one full-en entry -> one W beat of nibbles 0..31, strb=0xFFFF, last=1, entry dequeued, S_IDLE.
REQ-025 Two beats, one entry: rmn=1 then 0, lbn=32 -> beats of nibbles 0..31 and 32..63, last only on beat 2, dequeue on beat 2.
REQ-026 Unaligned head: addr_lo=8, lbn=32, rmn=0, final, ptr=0 -> bus nibbles 8..31 = entry 0..23, strb=0xFFF0, dequeue.
REQ-027 Entry split: ptr=48, addr_lo=0, lbn=32, final, two entries -> commit 1 moves 16 nibbles and dequeues, commit 2 moves entry2 0..15 to bus 16..31, one W beat, second dequeue.
REQ-028 Backpressure: axi_w_ready_i low for 5 cycles with a second beat pending -> W outputs stable, txn_ctrl_ready_o=0, then one beat per cycle after release.
REQ-029 Reset mid-split (after commit 1 of REQ-027) -> next cycle all outputs 0, SeqBuf empty, S_IDLE.

Source files
------------

// File: rtl/v_sequential_store.sv
// Sequential store path: buffers ShuffleUnit nibble entries and serialises them
// into AXI W beats, realigning between entry nibble pointer and bus nibble offset.
module v_sequential_store #(
  parameter  int unsigned NrLaneEntriesNbs = 64,
  parameter  int unsigned AxiDataWidth     = 128,
  localparam int unsigned BusNbs           = AxiDataWidth / 4,
  localparam int unsigned BNS              = $clog2(BusNbs),
  localparam int unsigned PtrW             = $clog2(NrLaneEntriesNbs)
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  // nibble entry from ShuffleUnit
  input  logic                          rx_shfu_valid_i,
  output logic                          rx_shfu_ready_o,
  input  logic [NrLaneEntriesNbs*4-1:0] rx_shfu_nb_i,
  input  logic [NrLaneEntriesNbs-1:0]   rx_shfu_en_i,
  // start nibble pointer
  input  logic                          meta_glb_valid_i,
  output logic                          meta_glb_ready_o,
  input  logic [PtrW-1:0]               meta_seq_nb_ptr_i,
  // per-beat transaction control
  input  logic                          txn_ctrl_valid_i,
  output logic                          txn_ctrl_ready_o,
  input  logic [BNS-1:0]                txn_addr_lo_i,
  input  logic [BNS:0]                  txn_lbn_i,
  input  logic [7:0]                    txn_rmn_beat_i,
  input  logic                          txn_is_head_i,
  input  logic                          txn_is_final_i,
  // AXI W channel
  output logic                          axi_w_valid_o,
  input  logic                          axi_w_ready_i,
  output logic [AxiDataWidth-1:0]       axi_w_data_o,
  output logic [AxiDataWidth/8-1:0]     axi_w_strb_o,
  output logic                          axi_w_last_o
);

  localparam int unsigned EntW  = NrLaneEntriesNbs * 4;
  localparam int unsigned StrbW = AxiDataWidth / 8;
  localparam int unsigned CntBW = BNS + 1;
  localparam int unsigned CntW  = ((BNS + 2) > (PtrW + 2)) ? (BNS + 2) : (PtrW + 2);

  localparam logic [0:0] S_IDLE   = 1'b0;
  localparam logic [0:0] S_SERIAL = 1'b1;

  logic [0:0] state_q, state_d;

  // SeqBuf: two entries, pointers carry a wrap flag above the index bit
  logic [EntW-1:0]             seq_data_q [2];
  logic [NrLaneEntriesNbs-1:0] seq_en_q   [2];
  logic [1:0]                  wr_ptr_q, rd_ptr_q;
  logic                        seq_empty, seq_full, enq, deq;

  logic [PtrW-1:0]  seq_nb_ptr_q, seq_nb_ptr_d;
  logic [CntBW-1:0] bus_nb_cnt_q, bus_nb_cnt_d;

  // W staging register
  logic [AxiDataWidth-1:0] w_data_q, w_data_d;
  logic [BusNbs-1:0]       written_q, written_d;
  logic                    w_last_q, w_last_d;
  logic                    w_valid_q, w_valid_d;
  logic                    w_fire;

  logic [CntW-1:0] lower, upper, bus_valid, seq_valid, nb_n, bus_start;
  logic [AxiDataWidth-1:0] bus_data_sh;
  logic [BusNbs-1:0]       bus_en_sh, win_mask, wr_mask;
  logic                    final_beat, commit, complete, meta_ready, txn_ready;

  assign seq_empty = (wr_ptr_q == rd_ptr_q);
  assign seq_full  = (wr_ptr_q[1] != rd_ptr_q[1]) && (wr_ptr_q[0] == rd_ptr_q[0]);

  assign rx_shfu_ready_o  = !seq_full && !rst_i;
  assign enq              = rx_shfu_valid_i && rx_shfu_ready_o;
  assign meta_glb_ready_o = meta_ready && !rst_i;
  assign txn_ctrl_ready_o = txn_ready && !rst_i;

  assign axi_w_valid_o = w_valid_q && !rst_i;
  assign axi_w_data_o  = w_data_q;
  assign axi_w_last_o  = w_last_q;
  assign w_fire        = axi_w_valid_o && axi_w_ready_i;

  // Byte strobe follows the low nibble of each byte
  always_comb begin
    axi_w_strb_o = '0;
    for (int j = 0; j < StrbW; j++) begin
      axi_w_strb_o[j] = written_q[2*j];
    end
  end

  // Commit arithmetic, one bit wider than any operand so nothing wraps
  always_comb begin
    lower      = txn_is_head_i ? CntW'(txn_addr_lo_i) : '0;
    upper      = (txn_rmn_beat_i == 8'd0) ? CntW'(txn_lbn_i) : CntW'(BusNbs);
    bus_valid  = upper - lower - CntW'(bus_nb_cnt_q);
    seq_valid  = CntW'(NrLaneEntriesNbs) - CntW'(seq_nb_ptr_q);
    nb_n       = (bus_valid < seq_valid) ? bus_valid : seq_valid;
    bus_start  = lower + CntW'(bus_nb_cnt_q);
    final_beat = txn_is_final_i && (txn_rmn_beat_i == 8'd0);
  end

  // Realign head entry onto the bus and build the nibble write window
  always_comb begin
    bus_data_sh = AxiDataWidth'(seq_data_q[rd_ptr_q[0]] >> {seq_nb_ptr_q, 2'b00})
                  << {bus_start, 2'b00};
    bus_en_sh   = BusNbs'(seq_en_q[rd_ptr_q[0]] >> seq_nb_ptr_q) << bus_start;
    win_mask    = '0;
    for (int i = 0; i < BusNbs; i++) begin
      win_mask[i] = (CntW'(i) >= bus_start) && (CntW'(i) < bus_start + nb_n);
    end
    wr_mask = win_mask & bus_en_sh;
  end

  assign commit = (state_q == S_SERIAL) && txn_ctrl_valid_i && !seq_empty &&
                  (!w_valid_q || axi_w_ready_i);

  // Next-state and control
  always_comb begin
    state_d      = state_q;
    seq_nb_ptr_d = seq_nb_ptr_q;
    bus_nb_cnt_d = bus_nb_cnt_q;
    meta_ready   = 1'b0;
    txn_ready    = 1'b0;
    complete     = 1'b0;
    deq          = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (txn_ctrl_valid_i && meta_glb_valid_i) begin
          meta_ready   = 1'b1;
          seq_nb_ptr_d = meta_seq_nb_ptr_i;
          bus_nb_cnt_d = '0;
          state_d      = S_SERIAL;
        end
      end
      S_SERIAL: begin
        if (commit) begin
          if (bus_valid > seq_valid) begin
            // entry exhausted before the beat fills: keep accumulating
            deq          = 1'b1;
            seq_nb_ptr_d = '0;
            bus_nb_cnt_d = bus_nb_cnt_q + CntBW'(nb_n);
          end else begin
            complete     = 1'b1;
            txn_ready    = 1'b1;
            bus_nb_cnt_d = '0;
            seq_nb_ptr_d = seq_nb_ptr_q + PtrW'(nb_n);
            if ((bus_valid == seq_valid) || final_beat) begin
              deq          = 1'b1;
              seq_nb_ptr_d = '0;
            end
            if (final_beat) begin
              state_d = S_IDLE;
            end
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Staging update: a departing beat clears first, then the commit merges in
  always_comb begin
    w_data_d  = w_fire ? '0 : w_data_q;
    written_d = w_fire ? '0 : written_q;
    w_valid_d = w_fire ? 1'b0 : w_valid_q;
    w_last_d  = w_last_q;
    if (commit) begin
      for (int i = 0; i < BusNbs; i++) begin
        if (wr_mask[i]) begin
          w_data_d[i*4 +: 4] = bus_data_sh[i*4 +: 4];
        end
      end
      written_d = written_d | wr_mask;
    end
    if (complete) begin
      w_valid_d = 1'b1;
      w_last_d  = (txn_rmn_beat_i == 8'd0);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      seq_nb_ptr_q <= '0;
      bus_nb_cnt_q <= '0;
      w_data_q     <= '0;
      written_q    <= '0;
      w_last_q     <= 1'b0;
      w_valid_q    <= 1'b0;
    end else begin
      if (enq) wr_ptr_q <= wr_ptr_q + 2'd1;
      if (deq) rd_ptr_q <= rd_ptr_q + 2'd1;
      seq_nb_ptr_q <= seq_nb_ptr_d;
      bus_nb_cnt_q <= bus_nb_cnt_d;
      w_data_q     <= w_data_d;
      written_q    <= written_d;
      w_last_q     <= w_last_d;
      w_valid_q    <= w_valid_d;
    end
  end

  // Entry storage needs no reset; pointers define validity
  always_ff @(posedge clk_i) begin
    if (enq) begin
      seq_data_q[wr_ptr_q[0]] <= rx_shfu_nb_i;
      seq_en_q[wr_ptr_q[0]]   <= rx_shfu_en_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i && (state_q == S_SERIAL) && txn_ctrl_valid_i) begin
      assert (upper <= CntW'(BusNbs))
        else $error("upper nibble bound exceeds bus width");
      assert (bus_valid <= CntW'(BusNbs))
        else $error("bus_valid exceeds bus width");
      assert (seq_valid <= CntW'(NrLaneEntriesNbs))
        else $error("seq_valid exceeds entry width");
    end
    if (!rst_i && w_valid_q) begin
      for (int j = 0; j < StrbW; j++) begin
        assert (written_q[2*j] == written_q[2*j+1])
          else $error("partial byte written in W beat");
      end
    end
  end

endmodule

// File: tb/tb_v_sequential_store.sv
// Directed bench for v_sequential_store: aligned, multi-beat, unaligned, split,
// backpressure and mid-split reset cases against hand-derived W beats.
module tb_v_sequential_store;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic         rx_shfu_valid_i, rx_shfu_ready_o;
  logic [255:0] rx_shfu_nb_i;
  logic [63:0]  rx_shfu_en_i;
  logic         meta_glb_valid_i, meta_glb_ready_o;
  logic [5:0]   meta_seq_nb_ptr_i;
  logic         txn_ctrl_valid_i, txn_ctrl_ready_o;
  logic [4:0]   txn_addr_lo_i;
  logic [5:0]   txn_lbn_i;
  logic [7:0]   txn_rmn_beat_i;
  logic         txn_is_head_i, txn_is_final_i;
  logic         axi_w_valid_o, axi_w_ready_i;
  logic [127:0] axi_w_data_o;
  logic [15:0]  axi_w_strb_o;
  logic         axi_w_last_o;

  int vectors = 0;
  int errors  = 0;
  int cyc     = 0;

  logic [127:0] got_data[$], exp_data[$];
  logic [15:0]  got_strb[$], exp_strb[$];
  logic         got_last[$], exp_last[$];
  int           got_cyc[$],  exp_cyc[$];

  v_sequential_store #(.NrLaneEntriesNbs(64), .AxiDataWidth(128)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .rx_shfu_valid_i(rx_shfu_valid_i), .rx_shfu_ready_o(rx_shfu_ready_o),
    .rx_shfu_nb_i(rx_shfu_nb_i), .rx_shfu_en_i(rx_shfu_en_i),
    .meta_glb_valid_i(meta_glb_valid_i), .meta_glb_ready_o(meta_glb_ready_o),
    .meta_seq_nb_ptr_i(meta_seq_nb_ptr_i),
    .txn_ctrl_valid_i(txn_ctrl_valid_i), .txn_ctrl_ready_o(txn_ctrl_ready_o),
    .txn_addr_lo_i(txn_addr_lo_i), .txn_lbn_i(txn_lbn_i),
    .txn_rmn_beat_i(txn_rmn_beat_i), .txn_is_head_i(txn_is_head_i),
    .txn_is_final_i(txn_is_final_i),
    .axi_w_valid_o(axi_w_valid_o), .axi_w_ready_i(axi_w_ready_i),
    .axi_w_data_o(axi_w_data_o), .axi_w_strb_o(axi_w_strb_o),
    .axi_w_last_o(axi_w_last_o)
  );

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  // W beat monitor, sampled mid-cycle
  always @(negedge clk_i) begin
    if (axi_w_valid_o && axi_w_ready_i) begin
      got_data.push_back(axi_w_data_o);
      got_strb.push_back(axi_w_strb_o);
      got_last.push_back(axi_w_last_o);
      got_cyc.push_back(cyc);
    end
  end

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [255:0] mk_entry(input int seed);
    logic [255:0] d;
    for (int k = 0; k < 64; k++) d[k*4 +: 4] = 4'((k * 5 + seed) & 15);
    return d;
  endfunction

  // bus nibbles [dst, dst+n) take entry nibbles [src, src+n)
  function automatic logic [127:0] place(input logic [255:0] ent, input int src,
                                         input int dst, input int n);
    logic [127:0] b;
    b = '0;
    for (int i = 0; i < n; i++) b[(dst + i)*4 +: 4] = ent[(src + i)*4 +: 4];
    return b;
  endfunction

  task automatic expect_beat(input logic [127:0] d, input logic [15:0] s,
                             input logic l, input int c);
    exp_data.push_back(d);
    exp_strb.push_back(s);
    exp_last.push_back(l);
    exp_cyc.push_back(c);
  endtask

  task automatic push_entry(input logic [255:0] d, input logic [63:0] en);
    bit ok;
    ok = 0;
    rx_shfu_valid_i = 1'b1;
    rx_shfu_nb_i    = d;
    rx_shfu_en_i    = en;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk_i);
      if (rx_shfu_ready_o) begin
        ok = 1;
        break;
      end
    end
    if (!ok) check_eq("push_timeout", 128'(ok), 128'(1));
    @(posedge clk_i); #1;
    rx_shfu_valid_i = 1'b0;
  endtask

  task automatic set_txn(input logic [4:0] a, input logic [5:0] l, input logic [7:0] r,
                         input logic h, input logic f);
    txn_ctrl_valid_i = 1'b1;
    txn_addr_lo_i    = a;
    txn_lbn_i        = l;
    txn_rmn_beat_i   = r;
    txn_is_head_i    = h;
    txn_is_final_i   = f;
  endtask

  task automatic start_txn(input logic [5:0] ptr, input logic [4:0] a, input logic [5:0] l,
                           input logic [7:0] r, input logic h, input logic f);
    set_txn(a, l, r, h, f);
    meta_glb_valid_i  = 1'b1;
    meta_seq_nb_ptr_i = ptr;
    @(negedge clk_i);
    check_eq("meta_ready_idle", 128'(meta_glb_ready_o), 128'(1));
    check_eq("txn_ready_idle", 128'(txn_ctrl_ready_o), 128'(0));
    @(posedge clk_i); #1;
    meta_glb_valid_i = 1'b0;
  endtask

  // Hold one beat's control until accepted; report cycles waited and accept cycle
  task automatic do_beat(input logic [4:0] a, input logic [5:0] l, input logic [7:0] r,
                         input logic h, input logic f, output int waits, output int c);
    waits = 0;
    c     = -100;
    set_txn(a, l, r, h, f);
    for (int t = 0; t < 20; t++) begin
      @(negedge clk_i);
      if (txn_ctrl_ready_o) begin
        waits = t + 1;
        c     = cyc;
        break;
      end
      @(posedge clk_i); #1;
    end
    if (waits == 0) check_eq("beat_timeout", 128'(waits), 128'(1));
    @(posedge clk_i); #1;
    txn_ctrl_valid_i = 1'b0;
  endtask

  task automatic check_beats(input string tag);
    int n;
    repeat (3) @(posedge clk_i);
    #1;
    check_eq({tag, "_nbeats"}, 128'(got_data.size()), 128'(exp_data.size()));
    n = (got_data.size() < exp_data.size()) ? got_data.size() : exp_data.size();
    for (int i = 0; i < n; i++) begin
      check_eq({tag, "_data"}, got_data[i], exp_data[i]);
      check_eq({tag, "_strb"}, 128'(got_strb[i]), 128'(exp_strb[i]));
      check_eq({tag, "_last"}, 128'(got_last[i]), 128'(exp_last[i]));
      if (exp_cyc[i] >= 0) check_eq({tag, "_cyc"}, 128'(got_cyc[i]), 128'(exp_cyc[i]));
    end
    got_data.delete(); got_strb.delete(); got_last.delete(); got_cyc.delete();
    exp_data.delete(); exp_strb.delete(); exp_last.delete(); exp_cyc.delete();
  endtask

  initial begin
    logic [255:0] ea, eb, ec, ed, ee, ef, eg, eh, ei;
    int w, c1, c2;
    ea = mk_entry(1); eb = mk_entry(2); ec = mk_entry(3);
    ed = mk_entry(4); ee = mk_entry(7); ef = mk_entry(11);
    eg = mk_entry(5); eh = mk_entry(13); ei = mk_entry(9);

    rst_i = 1'b1;
    rx_shfu_valid_i = 1'b0; rx_shfu_nb_i = '0; rx_shfu_en_i = '0;
    meta_glb_valid_i = 1'b0; meta_seq_nb_ptr_i = '0;
    txn_ctrl_valid_i = 1'b0; txn_addr_lo_i = '0; txn_lbn_i = '0;
    txn_rmn_beat_i = '0; txn_is_head_i = 1'b0; txn_is_final_i = 1'b0;
    axi_w_ready_i = 1'b1;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    check_eq("rst_rx_ready", 128'(rx_shfu_ready_o), 128'(0));
    check_eq("rst_w_valid", 128'(axi_w_valid_o), 128'(0));
    check_eq("rst_w_data", axi_w_data_o, 128'(0));
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    @(negedge clk_i);
    check_eq("idle_rx_ready", 128'(rx_shfu_ready_o), 128'(1));
    meta_glb_valid_i = 1'b1;
    #1;
    check_eq("meta_only_ready", 128'(meta_glb_ready_o), 128'(0));
    @(posedge clk_i); #1;
    meta_glb_valid_i = 1'b0;

    // aligned single beat
    push_entry(ea, '1);
    start_txn(6'd0, 5'd0, 6'd32, 8'd0, 1'b1, 1'b1);
    do_beat(5'd0, 6'd32, 8'd0, 1'b1, 1'b1, w, c1);
    check_eq("aligned_waits", 128'(w), 128'(1));
    expect_beat(place(ea, 0, 0, 32), 16'hFFFF, 1'b1, c1 + 1);
    check_beats("aligned");

    // two beats from one entry
    push_entry(eb, '1);
    start_txn(6'd0, 5'd0, 6'd32, 8'd1, 1'b1, 1'b0);
    do_beat(5'd0, 6'd32, 8'd1, 1'b1, 1'b0, w, c1);
    do_beat(5'd0, 6'd32, 8'd0, 1'b0, 1'b1, w, c2);
    check_eq("two_beat_b2_waits", 128'(w), 128'(1));
    expect_beat(place(eb, 0, 0, 32), 16'hFFFF, 1'b0, c1 + 1);
    expect_beat(place(eb, 32, 0, 32), 16'hFFFF, 1'b1, c2 + 1);
    check_beats("two_beat");

    // unaligned head
    push_entry(ec, '1);
    start_txn(6'd0, 5'd8, 6'd32, 8'd0, 1'b1, 1'b1);
    do_beat(5'd8, 6'd32, 8'd0, 1'b1, 1'b1, w, c1);
    expect_beat(place(ec, 0, 8, 24), 16'hFFF0, 1'b1, c1 + 1);
    check_beats("unaligned");

    // entry split across two commits
    push_entry(ed, '1);
    push_entry(ee, '1);
    check_eq("split_full", 128'(rx_shfu_ready_o), 128'(0));
    start_txn(6'd48, 5'd0, 6'd32, 8'd0, 1'b1, 1'b1);
    do_beat(5'd0, 6'd32, 8'd0, 1'b1, 1'b1, w, c1);
    check_eq("split_waits", 128'(w), 128'(2));
    expect_beat(place(ed, 48, 0, 16) | place(ee, 0, 16, 16), 16'hFFFF, 1'b1, c1 + 1);
    check_beats("split");
    check_eq("split_drained", 128'(rx_shfu_ready_o), 128'(1));

    // backpressure with a second beat pending
    axi_w_ready_i = 1'b0;
    push_entry(ef, '1);
    start_txn(6'd0, 5'd0, 6'd32, 8'd1, 1'b1, 1'b0);
    do_beat(5'd0, 6'd32, 8'd1, 1'b1, 1'b0, w, c1);
    set_txn(5'd0, 6'd32, 8'd0, 1'b0, 1'b1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk_i);
      check_eq("bp_valid", 128'(axi_w_valid_o), 128'(1));
      check_eq("bp_data", axi_w_data_o, place(ef, 0, 0, 32));
      check_eq("bp_last", 128'(axi_w_last_o), 128'(0));
      check_eq("bp_txn_ready", 128'(txn_ctrl_ready_o), 128'(0));
      @(posedge clk_i); #1;
    end
    axi_w_ready_i = 1'b1;
    do_beat(5'd0, 6'd32, 8'd0, 1'b0, 1'b1, w, c2);
    check_eq("bp_release_waits", 128'(w), 128'(1));
    expect_beat(place(ef, 0, 0, 32), 16'hFFFF, 1'b0, c2);
    expect_beat(place(ef, 32, 0, 32), 16'hFFFF, 1'b1, c2 + 1);
    check_beats("bp");

    // reset after the first commit of a split
    push_entry(eg, '1);
    push_entry(eh, '1);
    start_txn(6'd48, 5'd0, 6'd32, 8'd0, 1'b1, 1'b1);
    @(negedge clk_i);
    check_eq("rsplit_c1_ready", 128'(txn_ctrl_ready_o), 128'(0));
    @(posedge clk_i); #1;
    rst_i = 1'b1;
    txn_ctrl_valid_i = 1'b0;
    @(negedge clk_i);
    check_eq("rsplit_in_rst_rx", 128'(rx_shfu_ready_o), 128'(0));
    check_eq("rsplit_in_rst_wv", 128'(axi_w_valid_o), 128'(0));
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    @(negedge clk_i);
    check_eq("rsplit_w_valid", 128'(axi_w_valid_o), 128'(0));
    check_eq("rsplit_w_data", axi_w_data_o, 128'(0));
    check_eq("rsplit_w_strb", 128'(axi_w_strb_o), 128'(0));
    check_eq("rsplit_meta_rdy", 128'(meta_glb_ready_o), 128'(0));
    check_eq("rsplit_txn_rdy", 128'(txn_ctrl_ready_o), 128'(0));
    check_eq("rsplit_rx_rdy", 128'(rx_shfu_ready_o), 128'(1));
    check_beats("rsplit");

    // buffer must be empty: a fresh entry is the one stored
    push_entry(ei, '1);
    start_txn(6'd0, 5'd0, 6'd32, 8'd0, 1'b1, 1'b1);
    do_beat(5'd0, 6'd32, 8'd0, 1'b1, 1'b1, w, c1);
    expect_beat(place(ei, 0, 0, 32), 16'hFFFF, 1'b1, c1 + 1);
    check_beats("post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
